// File: rtl/gp_register_file.sv
// rtl/gp_register_file.sv - RV32 general-purpose register file with busy scoreboard
module gp_register_file #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic [NRD*AW-1:0]   i_rdAddr,
  output logic [NRD*XLEN-1:0] o_rdData,
  output logic [NRD-1:0]      o_rdBusy,
  input  logic                i_wrEn,
  input  logic [AW-1:0]       i_wrAddr,
  input  logic [XLEN-1:0]     i_wrData,
  input  logic                i_issueEn,
  input  logic [AW-1:0]       i_issueAddr,
  output logic [AW:0]         o_busyCnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     busy_cnt_next;

  logic wr_live;
  logic issue_live;

  assign wr_live    = i_wrEn && (i_wrAddr != '0);
  assign issue_live = i_issueEn && (i_issueAddr != '0);

  // Issue is applied after writeback so a new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy;
    if (wr_live) busy_next[i_wrAddr] = 1'b0;
    if (issue_live) busy_next[i_issueAddr] = 1'b1;
  end

  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy      <= '0;
      o_busyCnt <= '0;
    end else begin
      if (wr_live) regs[i_wrAddr] <= i_wrData;
      busy      <= busy_next;
      o_busyCnt <= busy_cnt_next;
    end
  end

  // Returns {busy, data}; the forwarding path is blocked while reset holds the array at zero.
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN:0] r;
    r = '0;
    if (addr != '0) begin
      if ((BYPASS != 0) && i_resetn && i_wrEn && (i_wrAddr == addr))
        r = {1'b0, i_wrData};
      else
        r = {busy[addr], regs[addr]};
    end
    return r;
  endfunction

  always_comb begin
    o_rdData = '0;
    o_rdBusy = '0;
    for (int k = 0; k < NRD; k++) begin
      {o_rdBusy[k], o_rdData[k*XLEN +: XLEN]} = read_port(i_rdAddr[k*AW +: AW]);
    end
  end

endmodule

// File: tb/tb_gp_register_file.sv
// tb/tb_gp_register_file.sv - directed vector bench for gp_register_file
module tb_gp_register_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                i_clk = 1'b0;
  logic                i_resetn;
  logic [NRD*AW-1:0]   i_rdAddr;
  logic                i_wrEn;
  logic [AW-1:0]       i_wrAddr;
  logic [XLEN-1:0]     i_wrData;
  logic                i_issueEn;
  logic [AW-1:0]       i_issueAddr;
  logic [NRD*XLEN-1:0] o_rdData,  nb_rdData;
  logic [NRD-1:0]      o_rdBusy,  nb_rdBusy;
  logic [AW:0]         o_busyCnt, nb_busyCnt;

  always #5 i_clk = ~i_clk;

  gp_register_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_rdAddr(i_rdAddr),
    .o_rdData(o_rdData), .o_rdBusy(o_rdBusy),
    .i_wrEn(i_wrEn), .i_wrAddr(i_wrAddr), .i_wrData(i_wrData),
    .i_issueEn(i_issueEn), .i_issueAddr(i_issueAddr), .o_busyCnt(o_busyCnt)
  );

  gp_register_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nb (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_rdAddr(i_rdAddr),
    .o_rdData(nb_rdData), .o_rdBusy(nb_rdBusy),
    .i_wrEn(i_wrEn), .i_wrAddr(i_wrAddr), .i_wrData(i_wrData),
    .i_issueEn(i_issueEn), .i_issueAddr(i_issueAddr), .o_busyCnt(nb_busyCnt)
  );

  typedef struct {
    logic [AW-1:0]   ra0, ra1;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            ie;
    logic [AW-1:0]   ia;
    logic [XLEN-1:0] d0, d1;
    logic            b0, b1;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] nb_d0;
    logic            nb_b0;
  } vec_t;

  vec_t vt [19];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [AW-1:0] ra0, ra1, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic ie, input logic [AW-1:0] ia);
    i_rdAddr = {ra1, ra0};
    i_wrEn = we; i_wrAddr = wa; i_wrData = wd;
    i_issueEn = ie; i_issueAddr = ia;
  endtask

  function automatic vec_t mk(input logic [AW-1:0] ra0, ra1, input logic we, input logic [AW-1:0] wa,
                              input logic [XLEN-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                              input logic [XLEN-1:0] d0, d1, input logic b0, b1, input logic [AW:0] cnt,
                              input logic [XLEN-1:0] nb_d0, input logic nb_b0);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.cnt = cnt; v.nb_d0 = nb_d0; v.nb_b0 = nb_b0;
    return v;
  endfunction

  initial begin
    //          ra0 ra1 we wa  wd            ie ia  d0            d1            b0 b1 cnt nb_d0         nb_b0
    vt[0]  = mk(0,  31, 0, 0,  0,            0, 0,  0,            0,            0, 0, 0,  0,            0);
    vt[1]  = mk(5,  5,  1, 5,  32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,  0,            0);
    vt[2]  = mk(5,  5,  0, 0,  0,            0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,  32'hDEADBEEF, 0);
    vt[3]  = mk(0,  0,  1, 0,  32'h1234,     0, 0,  0,            0,            0, 0, 0,  0,            0);
    vt[4]  = mk(0,  5,  0, 0,  0,            0, 0,  0,            32'hDEADBEEF, 0, 0, 0,  0,            0);
    vt[5]  = mk(7,  1,  1, 7,  32'hA5A5A5A5, 0, 0,  32'hA5A5A5A5, 0,            0, 0, 0,  0,            0);
    vt[6]  = mk(3,  7,  0, 0,  0,            1, 3,  0,            32'hA5A5A5A5, 0, 0, 0,  0,            0);
    vt[7]  = mk(3,  3,  0, 0,  0,            0, 0,  0,            0,            1, 1, 1,  0,            1);
    vt[8]  = mk(3,  2,  1, 3,  32'h11,       0, 0,  32'h11,       0,            0, 0, 1,  0,            1);
    vt[9]  = mk(3,  0,  0, 0,  0,            0, 0,  32'h11,       0,            0, 0, 0,  32'h11,       0);
    vt[10] = mk(9,  9,  0, 0,  0,            1, 9,  0,            0,            0, 0, 0,  0,            0);
    vt[11] = mk(9,  3,  1, 9,  32'h22,       1, 9,  32'h22,       32'h11,       0, 0, 1,  0,            1);
    vt[12] = mk(9,  9,  0, 0,  0,            0, 0,  32'h22,       32'h22,       1, 1, 1,  32'h22,       1);
    vt[13] = mk(0,  9,  0, 0,  0,            1, 0,  0,            32'h22,       0, 1, 1,  0,            0);
    vt[14] = mk(9,  0,  0, 0,  0,            1, 9,  32'h22,       0,            1, 0, 1,  32'h22,       1);
    vt[15] = mk(12, 9,  1, 12, 32'h77,       0, 0,  32'h77,       32'h22,       0, 1, 1,  0,            0);
    vt[16] = mk(12, 12, 0, 0,  0,            0, 0,  32'h77,       32'h77,       0, 0, 1,  32'h77,       0);
    vt[17] = mk(9,  12, 1, 9,  32'h33,       0, 0,  32'h33,       32'h77,       0, 0, 1,  32'h22,       1);
    vt[18] = mk(9,  31, 0, 0,  0,            0, 0,  32'h33,       0,            0, 0, 0,  32'h33,       0);

    i_resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;

    // Every address on every port reads zero and idle after reset.
    for (int a = 0; a < NREG; a++) begin
      drive(AW'(a), AW'(NREG-1-a), 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("rst_d0[%0d]", a), o_rdData[31:0], 0);
      chk($sformatf("rst_d1[%0d]", NREG-1-a), o_rdData[63:32], 0);
      chk($sformatf("rst_busy[%0d]", a), {30'd0, o_rdBusy}, 0);
    end
    chk("rst_cnt", {26'd0, o_busyCnt}, 0);
    @(negedge i_clk);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].ra0, vt[i].ra1, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ie, vt[i].ia);
      #2;
      chk($sformatf("v%0d_d0", i), o_rdData[31:0], vt[i].d0);
      chk($sformatf("v%0d_d1", i), o_rdData[63:32], vt[i].d1);
      chk($sformatf("v%0d_b0", i), {31'd0, o_rdBusy[0]}, {31'd0, vt[i].b0});
      chk($sformatf("v%0d_b1", i), {31'd0, o_rdBusy[1]}, {31'd0, vt[i].b1});
      chk($sformatf("v%0d_cnt", i), {26'd0, o_busyCnt}, {26'd0, vt[i].cnt});
      chk($sformatf("v%0d_nb_d0", i), nb_rdData[31:0], vt[i].nb_d0);
      chk($sformatf("v%0d_nb_b0", i), {31'd0, nb_rdBusy[0]}, {31'd0, vt[i].nb_b0});
      chk($sformatf("v%0d_nb_cnt", i), {26'd0, nb_busyCnt}, {26'd0, vt[i].cnt});
      @(negedge i_clk);
    end

    // Issue x1, x2, x4 on consecutive cycles; count follows one cycle later.
    drive(1, 2, 0, 0, 0, 1, 1);
    @(negedge i_clk); #1;
    chk("seq_cnt1", {26'd0, o_busyCnt}, 1);
    drive(1, 2, 0, 0, 0, 1, 2);
    @(negedge i_clk); #1;
    chk("seq_cnt2", {26'd0, o_busyCnt}, 2);
    drive(1, 4, 0, 0, 0, 1, 4);
    @(negedge i_clk); #1;
    chk("seq_cnt3", {26'd0, o_busyCnt}, 3);
    chk("seq_busy", {30'd0, o_rdBusy}, 3);

    // Asynchronous reset mid-cycle with a write in flight to x6.
    drive(5, 6, 1, 6, 32'h66, 1, 8);
    #1;
    i_resetn = 1'b0;
    #1;
    chk("arst_cnt", {26'd0, o_busyCnt}, 0);
    chk("arst_d0", o_rdData[31:0], 0);
    chk("arst_d1", o_rdData[63:32], 0);
    drive(1, 4, 1, 6, 32'h66, 1, 8);
    #1;
    chk("arst_busy", {30'd0, o_rdBusy}, 0);
    @(posedge i_clk); #1;
    chk("arst_hold_cnt", {26'd0, o_busyCnt}, 0);
    drive(6, 8, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    chk("arst_lost_wr", o_rdData[31:0], 0);
    chk("arst_lost_iss", {31'd0, o_rdBusy[1]}, 0);
    i_resetn = 1'b1;

    // First edge after release behaves normally.
    drive(0, 0, 1, 6, 32'h66, 1, 8);
    @(negedge i_clk); #1;
    drive(6, 8, 0, 0, 0, 0, 0);
    #1;
    chk("post_d0", o_rdData[31:0], 32'h66);
    chk("post_busy8", {31'd0, o_rdBusy[1]}, 1);
    chk("post_cnt", {26'd0, o_busyCnt}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
